// File: rtl/uart_rx_frontend_if.sv
// Bus-side signals of the UART receive front end.
//   rd       : one-cycle read strobe, consumes the held byte
//   rdata    : held received byte
//   dr       : data ready (level)
//   fe_set   : framing error pulse
//   crce_set : packet CRC mismatch pulse
//   or_set   : overrun pulse
//   nf_set   : noise pulse
// The slave modport is the receiver. The master modport is the status/bus block.
interface uart_rx_frontend_if;
  logic       rd;
  logic [7:0] rdata;
  logic       dr;
  logic       fe_set;
  logic       crce_set;
  logic       or_set;
  logic       nf_set;

  modport slave (
    input  rd,
    output rdata, dr, fe_set, crce_set, or_set, nf_set
  );

  modport master (
    output rd,
    input  rdata, dr, fe_set, crce_set, or_set, nf_set
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end.
// Oversamples rxd 16x and takes a 3-sample majority vote at the middle of each bit.
// It holds one received byte and flags framing, overrun and noise errors.
// Optional feature macro: RX_CRC8_EN. When defined, it adds a packet CRC-8 check byte
// after every PKT_LEN data bytes.
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   en           : receiver enable; low aborts the frame in progress
//   rxd          : asynchronous serial input, idle high
//   bus          : read strobe, held byte, dr level and error set pulses
module uart_rx_frontend #(
  parameter int unsigned DIVISOR = 16,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                rxd,
  uart_rx_frontend_if.slave   bus
);

  localparam int unsigned TICK_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIVISOR - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              state_q, state_d;
  logic                rxd_s1_q, rxd_s2_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic [3:0]          samp_cnt_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          shift_q;
  logic [1:0]          trip_q;
  logic                noise_q, stop_q, deliver_q;
  logic [7:0]          rdata_q;
  logic                dr_q, fe_q, or_q, nf_q;

  logic tick_c, at_t9_c, at_t15_c, maj_c, unan_c;
  logic start_det_c, eval_c, take_bit_c, adv_bit_c, finish_c;
  logic deliver_ok_c, data_c, load_c;

  // Sample timing and majority vote. The 7th and 8th samples are in trip_q, and rxd_s2_q is the 9th.
  assign tick_c   = (tick_cnt_q == TICK_LAST);
  assign at_t9_c  = tick_c && (samp_cnt_q == 4'd9);
  assign at_t15_c = tick_c && (samp_cnt_q == 4'd15);
  assign maj_c    = (trip_q[1] & trip_q[0]) | (trip_q[1] & rxd_s2_q) | (trip_q[0] & rxd_s2_q);
  assign unan_c   = (trip_q[1] == trip_q[0]) && (trip_q[0] == rxd_s2_q);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (!rxd_s2_q) state_d = S_START;
        S_START: begin
          if (at_t9_c && maj_c) state_d = S_IDLE;
          else if (at_t15_c)    state_d = S_DATA;
        end
        S_DATA:  if (at_t15_c && (bit_idx_q == 3'd7)) state_d = S_STOP;
        S_STOP:  if (at_t9_c) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM control strobes
  always_comb begin
    start_det_c = 1'b0;
    eval_c      = 1'b0;
    take_bit_c  = 1'b0;
    adv_bit_c   = 1'b0;
    finish_c    = 1'b0;
    if (en) begin
      start_det_c = (state_q == S_IDLE) && !rxd_s2_q;
      eval_c      = (state_q != S_IDLE) && at_t9_c;
      take_bit_c  = (state_q == S_DATA) && at_t9_c;
      adv_bit_c   = (state_q == S_DATA) && at_t15_c;
      finish_c    = (state_q == S_STOP) && at_t9_c;
    end
  end

  // Synchronizer, oversample counters and frame shift register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      trip_q     <= '0;
      noise_q    <= 1'b0;
      stop_q     <= 1'b0;
      deliver_q  <= 1'b0;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
      if (start_det_c || (state_q == S_IDLE)) tick_cnt_q <= '0;
      else if (tick_c)                        tick_cnt_q <= '0;
      else                                    tick_cnt_q <= TICK_W'(tick_cnt_q + 1'b1);
      if (start_det_c)                          samp_cnt_q <= '0;
      else if ((state_q != S_IDLE) && tick_c)   samp_cnt_q <= 4'(samp_cnt_q + 4'd1);
      if ((state_q != S_IDLE) && tick_c) trip_q <= {trip_q[0], rxd_s2_q};
      if (start_det_c)    bit_idx_q <= '0;
      else if (adv_bit_c) bit_idx_q <= 3'(bit_idx_q + 3'd1);
      if (take_bit_c) shift_q[bit_idx_q] <= maj_c;
      if (start_det_c)           noise_q <= 1'b0;
      else if (eval_c && !unan_c) noise_q <= 1'b1;
      if (finish_c) stop_q <= maj_c;
      deliver_q <= finish_c;
    end
  end

  assign deliver_ok_c = deliver_q && en;
  // A read in the same cycle as the delivery frees the holding register, so no overrun is flagged.
  assign load_c       = data_c && !(dr_q && !bus.rd);

  // Held byte, dr level and error pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
      dr_q    <= 1'b0;
      fe_q    <= 1'b0;
      or_q    <= 1'b0;
      nf_q    <= 1'b0;
    end else begin
      fe_q <= deliver_ok_c && !stop_q;
      nf_q <= deliver_ok_c && noise_q;
      or_q <= data_c && dr_q && !bus.rd;
      if (load_c) begin
        rdata_q <= shift_q;
        dr_q    <= 1'b1;
      end else if (bus.rd && dr_q) begin
        dr_q    <= 1'b0;
      end
    end
  end

`ifdef RX_CRC8_EN
  localparam int unsigned CNT_W = $clog2(PKT_LEN + 1);

  logic [7:0]       crc_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic             crce_q;
  logic             check_c;

  // CRC-8, polynomial 0x07, processed MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // A good frame in the last packet slot is the check byte and never reaches rdata.
  assign check_c = deliver_ok_c && stop_q && (pkt_cnt_q == CNT_W'(PKT_LEN));
  assign data_c  = deliver_ok_c && !check_c;

  // Packet byte counter and running CRC
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc_q     <= '0;
      pkt_cnt_q <= '0;
      crce_q    <= 1'b0;
    end else begin
      crce_q <= check_c && (shift_q != crc_q);
      if (!en || (deliver_ok_c && (!stop_q || check_c))) begin
        crc_q     <= '0;
        pkt_cnt_q <= '0;
      end else if (deliver_ok_c) begin
        crc_q     <= crc8_step(crc_q, shift_q);
        pkt_cnt_q <= CNT_W'(pkt_cnt_q + 1'b1);
      end
    end
  end

  assign bus.crce_set = crce_q;
`else
  assign data_c       = deliver_ok_c;
  assign bus.crce_set = 1'b0;

  // Empty marker block that elaborates only when PKT_LEN is out of range.
  if ((PKT_LEN == 0) || (PKT_LEN > 255)) begin : g_pkt_len_out_of_range
  end
`endif

  assign bus.rdata  = rdata_q;
  assign bus.dr     = dr_q;
  assign bus.fe_set = fe_q;
  assign bus.or_set = or_q;
  assign bus.nf_set = nf_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend with DIVISOR=4, so one bit time is 64 clks.
// A transaction-level model predicts the held byte, dr, and the pulse totals for each frame.
module tb_uart_rx_frontend;

  localparam int unsigned DIV = 4;
  localparam int BIT = 16 * DIV;
`ifdef RX_CRC8_EN
  localparam int unsigned PKT = 2;
`else
  localparam int unsigned PKT = 4;
`endif

  logic clk = 1'b0;
  logic reset_n, en, rxd;

  uart_rx_frontend_if bus ();

  uart_rx_frontend #(.DIVISOR(DIV), .PKT_LEN(PKT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .rxd     (rxd),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Totals of pulse-cycles seen on each set output; a stretched pulse counts more than once
  int fe_cnt = 0, or_cnt = 0, nf_cnt = 0, crce_cnt = 0;
  always @(negedge clk) begin
    if (bus.fe_set)   fe_cnt++;
    if (bus.or_set)   or_cnt++;
    if (bus.nf_set)   nf_cnt++;
    if (bus.crce_set) crce_cnt++;
  end

  // Reference model state
  logic [7:0] rdata_m = 8'h00;
  logic       dr_m    = 1'b0;
  int exp_fe = 0, exp_or = 0, exp_nf = 0, exp_crce = 0;
`ifdef RX_CRC8_EN
  logic [7:0] pkt_q[$];

  // Remainder of (packet * x^8) mod x^8+x^2+x+1, by long division.
  function automatic logic [7:0] crc_model();
    logic [8:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i <= pkt_q.size(); i++) begin
      b = (i < pkt_q.size()) ? pkt_q[i] : 8'h00;
      for (int k = 7; k >= 0; k--) begin
        r = {r[7:0], b[k]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    return r[7:0];
  endfunction
`endif

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'(rdata_m));
    check({tag, "_dr"},    32'(bus.dr),    32'(dr_m));
    check({tag, "_fe"},    32'(fe_cnt),    32'(exp_fe));
    check({tag, "_or"},    32'(or_cnt),    32'(exp_or));
    check({tag, "_nf"},    32'(nf_cnt),    32'(exp_nf));
    check({tag, "_crce"},  32'(crce_cnt),  32'(exp_crce));
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model of one received frame; the bench never issues rd in a deliver cycle.
  task automatic model_data(input logic [7:0] b);
    if (dr_m) exp_or++;
    else begin
      rdata_m = b;
      dr_m    = 1'b1;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop, input int glitch);
    if (glitch >= 0) exp_nf++;
    if (!stop) begin
      exp_fe++;
`ifdef RX_CRC8_EN
      pkt_q.delete();
`endif
      model_data(b);
    end
`ifdef RX_CRC8_EN
    else if (pkt_q.size() == PKT) begin
      if (b != crc_model()) exp_crce++;
      pkt_q.delete();
    end
`endif
    else begin
`ifdef RX_CRC8_EN
      pkt_q.push_back(b);
`endif
      model_data(b);
    end
  endtask

  // Bit slots: 0=start, 1..8=data LSB first, 9=stop. The glitch inverts only the middle (8th) sample.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < BIT; c++) begin
        @(posedge clk);
        #1;
        rxd = bits[bi] ^ ((bi == glitch) && (c >= 35) && (c < 38));
      end
    end
    @(posedge clk);
    #1;
    rxd = 1'b1;
    wait_clks(80);
    model_frame(b, stop, glitch);
  endtask

  task automatic do_rd();
    @(posedge clk);
    #1;
    bus.rd = 1'b1;
    @(posedge clk);
    #1;
    bus.rd = 1'b0;
    dr_m = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    int         rgl;

    reset_n = 1'b0;
    en      = 1'b1;
    rxd     = 1'b1;
    bus.rd  = 1'b0;
    wait_clks(4);
    check("rst_rdata", 32'(bus.rdata), 32'h00);
    check("rst_dr",    32'(bus.dr),    32'h0);
    check("rst_pulses", 32'({bus.fe_set, bus.or_set, bus.nf_set, bus.crce_set}), 32'h0);
    reset_n = 1'b1;
    wait_clks(10);

    // Clean byte, then read
    send_frame(8'hA5, 1'b1, -1);
    check_model("t1");
    check("t1_const_rdata", 32'(bus.rdata), 32'hA5);
    do_rd();
    check("t1_dr_after_rd", 32'(bus.dr), 32'h0);

    // Overrun
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    check_model("t2");
    do_rd();

    // Framing error: the byte is still delivered
    send_frame(8'h3C, 1'b0, -1);
    check_model("t3");
    do_rd();

    // Noise on the middle sample of data bit 2
    send_frame(8'h5A, 1'b1, 3);
    check_model("t4");
    do_rd();

    // False start: low for 4 ticks only
    @(posedge clk);
    #1;
    rxd = 1'b0;
    wait_clks(4 * DIV);
    rxd = 1'b1;
    wait_clks(2 * BIT);
    check_model("t5");
    send_frame(8'hC3, 1'b1, -1);
    check_model("t5_after");
    do_rd();

    // Drop en mid-frame: abort, no pulses, held byte kept
    send_frame(8'h77, 1'b1, -1);
    @(posedge clk);
    #1;
    rxd = 1'b0;
    wait_clks(3 * BIT);
    en = 1'b0;
    wait_clks(10);
    rxd = 1'b1;
    wait_clks(4);
    en = 1'b1;
`ifdef RX_CRC8_EN
    pkt_q.delete();
`endif
    wait_clks(2 * BIT);
    check_model("abort");
    do_rd();
    send_frame(8'h96, 1'b1, -1);
    check_model("abort_after");
    do_rd();

    // Randomized frames with random errors and reads
    for (int i = 0; i < 20; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 99) >= 15);
      rgl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      send_frame(rb, rstop, rgl);
      check_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) do_rd();
    end

`ifdef RX_CRC8_EN
    // Packet CRC: toggling en restarts the packet
    en = 1'b0;
    wait_clks(4);
    en = 1'b1;
    pkt_q.delete();
    wait_clks(4);
    if (dr_m) do_rd();
    send_frame(8'h01, 1'b1, -1);
    do_rd();
    send_frame(8'h02, 1'b1, -1);
    do_rd();
    send_frame(8'h1B, 1'b1, -1);
    check_model("crc_good");
    check("crc_good_dr",    32'(bus.dr),    32'h0);
    check("crc_good_rdata", 32'(bus.rdata), 32'h02);
    send_frame(8'h01, 1'b1, -1);
    do_rd();
    send_frame(8'h02, 1'b1, -1);
    do_rd();
    send_frame(8'h1C, 1'b1, -1);
    check_model("crc_bad");
    check("crc_bad_dr", 32'(bus.dr), 32'h0);
`endif

    // Reset in the middle of a frame
    send_frame(8'hE1, 1'b1, -1);
    @(posedge clk);
    #1;
    rxd = 1'b0;
    wait_clks(4 * BIT);
    reset_n = 1'b0;
    wait_clks(3);
    rxd = 1'b1;
    wait_clks(2);
    reset_n = 1'b1;
    rdata_m = 8'h00;
    dr_m    = 1'b0;
`ifdef RX_CRC8_EN
    pkt_q.delete();
`endif
    wait_clks(2 * BIT);
    check_model("midrst");
    send_frame(8'h4B, 1'b1, -1);
    check_model("midrst_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
